// File: rtl/cfg_frame_rx.sv
// Serial configuration frame receiver: captures a DYNCNF word (SEL=1) followed by a STATCNF word (SEL=0).
// Optional CFG_MATCH comparator output is enabled by defining CFG_FRAME_RX_CHECK_EN.
module cfg_frame_rx #(
    parameter int unsigned SIZESRDYN      = 16,
    parameter int unsigned SIZESRSTAT     = 88,
    parameter int unsigned TIMEOUT_CYCLES = 64
`ifdef CFG_FRAME_RX_CHECK_EN
    ,
    parameter logic [SIZESRDYN-1:0]  BIT_SEQUENCE_DIN_EXP  = 16'hABC6,
    parameter logic [SIZESRSTAT-1:0] BIT_SEQUENCE_STAT_EXP = 88'h123456789ABCDEF1234567
`endif
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  SCLK_IN,
    input  logic                  SEL_IN,
    input  logic                  MOSI_IN,
    input  logic                  ARM,
    output logic [SIZESRDYN-1:0]  DYNCNF_OUT,
    output logic [SIZESRSTAT-1:0] STATCNF_OUT,
    output logic                  FRAME_VALID,
    output logic                  FRAME_DONE,
    output logic                  ERR,
    output logic [1:0]            ERR_CODE
`ifdef CFG_FRAME_RX_CHECK_EN
    ,
    output logic                  CFG_MATCH
`endif
);

    localparam int unsigned CNT_W  = 7;
    localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES) + 1;

    localparam logic [1:0] ERR_LEN = 2'd1;
    localparam logic [1:0] ERR_SEL = 2'd2;
    localparam logic [1:0] ERR_TMO = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HUNT,
        S_DYN,
        S_STAT,
        S_DONE,
        S_ERR
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic r_sclk_s1, r_sclk_s2, r_sclk_prev;
    logic r_sel_s1, r_sel_s2;
    logic r_mosi_s1, r_mosi_s2;

    logic [SIZESRDYN-1:0]  r_dyn_sh;
    logic [SIZESRSTAT-1:0] r_stat_sh;
    logic [SIZESRDYN-1:0]  r_dyn_out;
    logic [SIZESRSTAT-1:0] r_stat_out;
    logic [CNT_W-1:0]      r_bit_cnt;
    logic [IDLE_W-1:0]     r_idle_cnt;
    logic [1:0]            r_err_code;
    logic                  r_err;
    logic                  r_frame_done;
    logic                  r_frame_valid;
    logic                  r_latch_req;

    logic             w_edge;
    logic             w_timeout;
    logic             w_clear;
    logic             w_shift_dyn;
    logic             w_shift_stat;
    logic             w_latch_req;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [1:0]       w_err_code_nxt;

    assign w_edge    = r_sclk_s2 & ~r_sclk_prev;
    assign w_timeout = (r_idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1));
    assign w_cnt_inc = r_bit_cnt + CNT_W'(1);

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and datapath control; ARM=0 overrides everything, an edge beats a timeout
    always_comb begin
        w_state_nxt    = r_state;
        w_err_code_nxt = r_err_code;
        w_cnt_nxt      = r_bit_cnt;
        w_shift_dyn    = 1'b0;
        w_shift_stat   = 1'b0;
        w_latch_req    = 1'b0;
        w_clear        = 1'b0;
        if (!ARM) begin
            w_state_nxt    = S_IDLE;
            w_err_code_nxt = 2'd0;
            w_cnt_nxt      = '0;
            w_clear        = 1'b1;
        end else begin
            case (r_state)
                S_IDLE: w_state_nxt = S_HUNT;
                S_HUNT: begin
                    if (w_edge && r_sel_s2) begin
                        w_shift_dyn = 1'b1;
                        w_cnt_nxt   = CNT_W'(1);
                        w_state_nxt = S_DYN;
                    end
                end
                S_DYN: begin
                    if (w_edge) begin
                        if (r_sel_s2) begin
                            if (r_bit_cnt == CNT_W'(SIZESRDYN)) begin
                                w_state_nxt    = S_ERR;
                                w_err_code_nxt = ERR_LEN;
                            end else begin
                                w_shift_dyn = 1'b1;
                                w_cnt_nxt   = w_cnt_inc;
                            end
                        end else if (r_bit_cnt == CNT_W'(SIZESRDYN)) begin
                            w_shift_stat = 1'b1;
                            w_cnt_nxt    = CNT_W'(1);
                            w_state_nxt  = S_STAT;
                        end else begin
                            w_state_nxt    = S_ERR;
                            w_err_code_nxt = ERR_LEN;
                        end
                    end else if (w_timeout) begin
                        w_state_nxt    = S_ERR;
                        w_err_code_nxt = ERR_TMO;
                    end
                end
                S_STAT: begin
                    if (w_edge) begin
                        if (r_sel_s2) begin
                            w_state_nxt    = S_ERR;
                            w_err_code_nxt = ERR_SEL;
                        end else begin
                            w_shift_stat = 1'b1;
                            w_cnt_nxt    = w_cnt_inc;
                            if (w_cnt_inc == CNT_W'(SIZESRSTAT)) begin
                                w_state_nxt = S_DONE;
                                w_latch_req = 1'b1;
                            end
                        end
                    end else if (w_timeout) begin
                        w_state_nxt    = S_ERR;
                        w_err_code_nxt = ERR_TMO;
                    end
                end
                S_DONE: ;
                S_ERR:  ;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Synchronizers, shift registers, counters and registered outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sclk_s1     <= 1'b0;
            r_sclk_s2     <= 1'b0;
            r_sclk_prev   <= 1'b0;
            r_sel_s1      <= 1'b0;
            r_sel_s2      <= 1'b0;
            r_mosi_s1     <= 1'b0;
            r_mosi_s2     <= 1'b0;
            r_dyn_sh      <= '0;
            r_stat_sh     <= '0;
            r_dyn_out     <= '0;
            r_stat_out    <= '0;
            r_bit_cnt     <= '0;
            r_idle_cnt    <= '0;
            r_err_code    <= 2'd0;
            r_err         <= 1'b0;
            r_frame_done  <= 1'b0;
            r_frame_valid <= 1'b0;
            r_latch_req   <= 1'b0;
        end else begin
            r_sclk_s1   <= SCLK_IN;
            r_sclk_s2   <= r_sclk_s1;
            r_sclk_prev <= r_sclk_s2;
            r_sel_s1    <= SEL_IN;
            r_sel_s2    <= r_sel_s1;
            r_mosi_s1   <= MOSI_IN;
            r_mosi_s2   <= r_mosi_s1;

            if (w_shift_dyn) begin
                r_dyn_sh <= {r_dyn_sh[SIZESRDYN-2:0], r_mosi_s2};
            end
            if (w_shift_stat) begin
                r_stat_sh <= {r_stat_sh[SIZESRSTAT-2:0], r_mosi_s2};
            end

            r_bit_cnt <= w_cnt_nxt;
            if (w_clear || w_edge) begin
                r_idle_cnt <= '0;
            end else if (!w_timeout) begin
                r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
            end

            r_err_code   <= w_err_code_nxt;
            r_err        <= (w_state_nxt == S_ERR);
            r_frame_done <= (w_state_nxt == S_DONE);
            r_latch_req  <= w_latch_req;

            // Complete words move to the outputs together, one cycle after the last bit
            r_frame_valid <= r_latch_req & ARM;
            if (r_latch_req && ARM) begin
                r_dyn_out  <= r_dyn_sh;
                r_stat_out <= r_stat_sh;
            end
        end
    end

`ifdef CFG_FRAME_RX_CHECK_EN
    logic r_cfg_match;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cfg_match <= 1'b0;
        end else if (!ARM) begin
            r_cfg_match <= 1'b0;
        end else if (r_latch_req) begin
            r_cfg_match <= (r_dyn_sh == BIT_SEQUENCE_DIN_EXP) &&
                           (r_stat_sh == BIT_SEQUENCE_STAT_EXP);
        end
    end

    assign CFG_MATCH = r_cfg_match;
`endif

    assign DYNCNF_OUT  = r_dyn_out;
    assign STATCNF_OUT = r_stat_out;
    assign FRAME_VALID = r_frame_valid;
    assign FRAME_DONE  = r_frame_done;
    assign ERR         = r_err;
    assign ERR_CODE    = r_err_code;

endmodule

// File: tb/tb_cfg_frame_rx.sv
// Scoreboard bench for cfg_frame_rx: a frame-level reference model predicts each frame's outcome.
module tb_cfg_frame_rx;

    localparam int K_GOOD = 0;
    localparam int K_ERR  = 1;
    localparam int K_NONE = 2;

    typedef struct {
        logic sel;
        logic b;
    } ev_t;

    typedef struct {
        int          kind;
        logic [1:0]  code;
        logic [15:0] dyn;
        logic [87:0] stat;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        SCLK_IN = 1'b0;
    logic        SEL_IN = 1'b0;
    logic        MOSI_IN = 1'b0;
    logic        ARM = 1'b0;
    logic [15:0] DYNCNF_OUT;
    logic [87:0] STATCNF_OUT;
    logic        FRAME_VALID;
    logic        FRAME_DONE;
    logic        ERR;
    logic [1:0]  ERR_CODE;
`ifdef CFG_FRAME_RX_CHECK_EN
    logic        CFG_MATCH;
`endif

    cfg_frame_rx dut (
        .CLK        (CLK),
        .RST        (RST),
        .SCLK_IN    (SCLK_IN),
        .SEL_IN     (SEL_IN),
        .MOSI_IN    (MOSI_IN),
        .ARM        (ARM),
        .DYNCNF_OUT (DYNCNF_OUT),
        .STATCNF_OUT(STATCNF_OUT),
        .FRAME_VALID(FRAME_VALID),
        .FRAME_DONE (FRAME_DONE),
        .ERR        (ERR),
        .ERR_CODE   (ERR_CODE)
`ifdef CFG_FRAME_RX_CHECK_EN
        ,
        .CFG_MATCH  (CFG_MATCH)
`endif
    );

    always #5 CLK = ~CLK;

    int          tests = 0;
    int          fails = 0;
    exp_t        sb[$];
    logic [15:0] last_dyn = '0;
    logic [87:0] last_stat = '0;
    logic        prev_err = 1'b0;
    logic        prev_fv = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Frame-level reference: ignore SEL=0 until the first SEL=1, expect 16 SEL=1 bits then 88 SEL=0 bits
    function automatic exp_t model(input ev_t ev[$], input logic [15:0] ld, input logic [87:0] ls);
        exp_t        r;
        int          i;
        int          nd;
        int          ns;
        logic [15:0] d;
        logic [87:0] s;
        r.kind = K_ERR; r.code = 2'd0; r.dyn = ld; r.stat = ls;
        i = 0; nd = 0; ns = 0; d = '0; s = '0;
        while (i < ev.size() && !ev[i].sel) i++;
        if (i == ev.size()) begin r.kind = K_NONE; return r; end
        while (i < ev.size() && ev[i].sel) begin
            if (nd == 16) begin r.code = 2'd1; return r; end
            d = {d[14:0], ev[i].b}; nd++; i++;
        end
        if (i == ev.size()) begin r.code = 2'd3; return r; end
        if (nd != 16) begin r.code = 2'd1; return r; end
        while (i < ev.size() && ns < 88) begin
            if (ev[i].sel) begin r.code = 2'd2; return r; end
            s = {s[86:0], ev[i].b}; ns++; i++;
        end
        if (ns < 88) begin r.code = 2'd3; return r; end
        r.kind = K_GOOD; r.dyn = d; r.stat = s;
        return r;
    endfunction

    task automatic build(input logic [15:0] d, input logic [87:0] s, input int lead, input int nd,
                         input int ns, input int viol, output ev_t q[$]);
        ev_t e;
        q.delete();
        for (int i = 0; i < lead; i++) begin e.sel = 1'b0; e.b = 1'($urandom); q.push_back(e); end
        for (int i = 0; i < nd; i++) begin
            e.sel = 1'b1;
            e.b   = (i < 16) ? d[4'(15 - i)] : 1'($urandom);
            q.push_back(e);
        end
        for (int i = 0; i < ns; i++) begin
            e.sel = (i == viol);
            e.b   = s[7'(87 - i)];
            q.push_back(e);
        end
    endtask

    // Serial clock at CLK/8; data changes while SCLK is low
    task automatic send(input ev_t q[$]);
        foreach (q[i]) begin
            SEL_IN  = q[i].sel;
            MOSI_IN = q[i].b;
            SCLK_IN = 1'b0;
            repeat (4) @(negedge CLK);
            SCLK_IN = 1'b1;
            repeat (4) @(negedge CLK);
        end
        SCLK_IN = 1'b0;
    endtask

    task automatic run_frame(input ev_t q[$], input bit meas_to);
        exp_t e;
        int   cyc;
        e = model(q, last_dyn, last_stat);
        if (e.kind == K_GOOD) begin last_dyn = e.dyn; last_stat = e.stat; end
        if (e.kind != K_NONE) sb.push_back(e);
        send(q);
        if (meas_to) begin
            cyc = 4;
            while (!ERR && cyc < 200) begin @(negedge CLK); cyc++; end
            chk("timeout_latency", 128'(cyc >= 64 && cyc <= 70), 128'(1));
        end
        cyc = 0;
        while (sb.size() != 0 && cyc < 400) begin @(negedge CLK); cyc++; end
        if (sb.size() != 0) begin
            tests++; fails++;
            $display("FAIL event_wait: %0d outstanding after %0d cycles", sb.size(), cyc);
            sb.delete();
        end
        ARM = 1'b0;
        @(negedge CLK);
        chk("disarm_err", 128'(ERR), 128'(0));
        chk("disarm_code", 128'(ERR_CODE), 128'(0));
        chk("disarm_done", 128'(FRAME_DONE), 128'(0));
        chk("hold_dyn", 128'(DYNCNF_OUT), 128'(last_dyn));
        chk("hold_stat", 128'(STATCNF_OUT), 128'(last_stat));
`ifdef CFG_FRAME_RX_CHECK_EN
        chk("disarm_match", 128'(CFG_MATCH), 128'(0));
`endif
        ARM = 1'b1;
        repeat (2) @(negedge CLK);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_dyn"}, 128'(DYNCNF_OUT), 128'(0));
        chk({tag, "_stat"}, 128'(STATCNF_OUT), 128'(0));
        chk({tag, "_fv"}, 128'(FRAME_VALID), 128'(0));
        chk({tag, "_done"}, 128'(FRAME_DONE), 128'(0));
        chk({tag, "_err"}, 128'(ERR), 128'(0));
        chk({tag, "_code"}, 128'(ERR_CODE), 128'(0));
    endtask

    // Monitor: every FRAME_VALID pulse or ERR rise consumes one scoreboard entry
    always @(negedge CLK) begin : mon
        exp_t e;
        if (!RST && (FRAME_VALID || (ERR && !prev_err))) begin
            if (sb.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_event: fv=%0b err=%0b code=%0d, none expected",
                         FRAME_VALID, ERR, ERR_CODE);
            end else begin
                e = sb.pop_front();
                chk("event_kind", 128'(FRAME_VALID ? K_GOOD : K_ERR), 128'(e.kind));
                if (e.kind == K_GOOD) begin
                    chk("fv_single", 128'(prev_fv), 128'(0));
                    chk("frame_dyn", 128'(DYNCNF_OUT), 128'(e.dyn));
                    chk("frame_stat", 128'(STATCNF_OUT), 128'(e.stat));
                    chk("frame_done", 128'(FRAME_DONE), 128'(1));
                    chk("frame_err", 128'(ERR), 128'(0));
`ifdef CFG_FRAME_RX_CHECK_EN
                    chk("cfg_match", 128'(CFG_MATCH),
                        128'(e.dyn == 16'hABC6 && e.stat == 88'h123456789ABCDEF1234567));
`endif
                end else begin
                    chk("err_code", 128'(ERR_CODE), 128'(e.code));
                    chk("err_keep_dyn", 128'(DYNCNF_OUT), 128'(e.dyn));
                    chk("err_keep_stat", 128'(STATCNF_OUT), 128'(e.stat));
                    chk("err_no_fv", 128'(FRAME_VALID), 128'(0));
                end
            end
        end
        prev_err = ERR;
        prev_fv  = FRAME_VALID;
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        ev_t         q[$];
        logic [15:0] d;
        logic [87:0] s;
        int          kind;

        RST = 1'b1;
        repeat (3) @(negedge CLK);
        chk_all_zero("reset");
        RST = 1'b0;
        ARM = 1'b0;
        repeat (100) @(negedge CLK);
        chk_all_zero("idle_unarmed");
        ARM = 1'b1;
        repeat (2) @(negedge CLK);

        build(16'hABC6, 88'h123456789ABCDEF1234567, 0, 16, 88, -1, q);
        run_frame(q, 1'b0);
        build(16'hABC6, 88'h123456789ABCDEF1234566, 0, 16, 88, -1, q);
        run_frame(q, 1'b0);
        build(16'h1357, 88'hFEDCBA9876543210ABCDEF, 0, 15, 88, -1, q);
        run_frame(q, 1'b0);
        build(16'h5A5A, 88'h0F0F0F0F0F0F0F0F0F0F0F, 0, 16, 88, 40, q);
        run_frame(q, 1'b0);
        build(16'h2468, 88'hAAAAAAAAAAAAAAAAAAAAAA, 0, 16, 50, -1, q);
        run_frame(q, 1'b1);
        build(16'h8001, 88'h8000000000000000000001, 2, 16, 88, -1, q);
        run_frame(q, 1'b0);

        // Reset in the middle of the dynamic word
        build(16'hFFFF, 88'h0, 0, 8, 0, -1, q);
        send(q);
        repeat (4) @(negedge CLK);
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        chk_all_zero("midreset");
        last_dyn  = '0;
        last_stat = '0;
        RST = 1'b0;
        @(negedge CLK);
        build(16'hABC6, 88'h123456789ABCDEF1234567, 0, 16, 88, -1, q);
        run_frame(q, 1'b0);

        for (int n = 0; n < 20; n++) begin
            d    = 16'($urandom);
            s    = {24'($urandom), 32'($urandom), 32'($urandom)};
            kind = int'($urandom_range(0, 4));
            case (kind)
                0: build(d, s, int'($urandom_range(0, 3)), 16, 88, -1, q);
                1: build(d, s, 0, int'($urandom_range(1, 15)), 88, -1, q);
                2: build(d, s, 0, int'($urandom_range(17, 18)), 88, -1, q);
                3: build(d, s, 0, 16, 88, int'($urandom_range(0, 87)), q);
                default: build(d, s, 0, 16, int'($urandom_range(1, 87)), -1, q);
            endcase
            run_frame(q, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cfg_frame_rx.md
Name: cfg_frame_rx

Overview:
- Receive-side counterpart of the DYNCNF/STATCNF serial configuration sender. Deserializes the MOSI stream qualified by the gated serial clock and SEL.
- Used as the ASIC-side configuration-register model in system benches, and as an on-chip loopback/readback monitor.
- Captures one 16-bit DYNCNF word while SEL=1, then one 88-bit STATCNF word while SEL=0. Checks framing, then presents both words atomically.

Parameters:
SIZESRDYN, 16, dynamic register length (bits with SEL=1)
SIZESRSTAT, 88, static register length (bits with SEL=0)
TIMEOUT_CYCLES, 64, CLK cycles without a serial-clock rising edge before a mid-frame abort
BIT_SEQUENCE_DIN_EXP, 16'hABC6, expected DYNCNF (used only with the optional feature)
BIT_SEQUENCE_STAT_EXP, 88'h123456789ABCDEF1234567, expected STATCNF (used only with the optional feature)

Ports:
CLK  input  1  fast system clock; f_CLK >= 4x serial clock
RST  input  1  synchronous, active-high reset
SCLK_IN  input  1  gated serial clock (CLK_ON_OFF of the sender), asynchronous to CLK
SEL_IN  input  1  register select: 1 = dynamic, 0 = static; asynchronous
MOSI_IN  input  1  serial data, MSB first; asynchronous
ARM  input  1  level; 1 = accept a frame, 0 = abort/clear to IDLE
DYNCNF_OUT  output  16  last good dynamic word
STATCNF_OUT  output  88  last good static word
FRAME_VALID  output  1  one-CLK pulse when a good frame is latched
FRAME_DONE  output  1  level, high in DONE
ERR  output  1  level, high in ERR
ERR_CODE  output  2  1 = dynamic length, 2 = SEL high in static, 3 = timeout; 0 otherwise

Behaviour:
- Reset: all outputs 0, FSM IDLE, counters 0, shift registers 0. Reset mid-frame discards partial data.
- Input conditioning: SCLK_IN, SEL_IN and MOSI_IN each pass through a 2-flop synchronizer. An extra SCLK history flop gives edge = sync & ~prev. SEL and MOSI are sampled on the edge cycle. Bit capture lands 3 CLK cycles after the SCLK rise.
- Shifting is MSB first: shreg <= {shreg[N-2:0], bit}. The first received bit ends up at the MSB.
- bit_cnt is 7 bits. idle_cnt counts CLK cycles since the last edge and is cleared on every edge.
- FSM:
  - IDLE: ARM=1 -> HUNT.
  - HUNT: edges with SEL=0 are ignored. The first edge with SEL=1 shifts into the dynamic register, sets bit_cnt=1, and goes to DYN. No timeout in HUNT.
  - DYN, edge with SEL=1: if bit_cnt==16 -> ERR code 1; else shift and bit_cnt++.
  - DYN, edge with SEL=0: if bit_cnt==16 -> shift into the static register, bit_cnt=1, go to STAT; else ERR code 1.
  - STAT, edge with SEL=1: ERR code 2.
  - STAT, edge with SEL=0: shift and bit_cnt++. On the edge that makes the count 88, go to DONE.
  - STAT completion: on the following cycle DYNCNF_OUT/STATCNF_OUT load together and FRAME_VALID pulses for 1 cycle.
  - DONE: all edges ignored; FRAME_DONE=1.
  - ERR: all edges ignored; ERR=1; ERR_CODE is held.
- Timeout: in DYN/STAT, idle_cnt reaching TIMEOUT_CYCLES-1 -> ERR code 3. If a timeout and an edge coincide, the edge wins and idle_cnt clears.
- ARM=0 in any state -> IDLE next cycle, clearing ERR, ERR_CODE, FRAME_DONE and the counters. DYNCNF_OUT/STATCNF_OUT keep their last good values. ARM=0 takes priority over a simultaneous edge.
- Outputs never show partial data. They change only on a good-frame latch or on RST.

Optional Feature:
- Macro: CFG_FRAME_RX_CHECK_EN.
- Defined: adds output CFG_MATCH (1 bit, reset 0). It is updated in the same cycle as FRAME_VALID to (dyn==BIT_SEQUENCE_DIN_EXP && stat==BIT_SEQUENCE_STAT_EXP). It clears to 0 on ARM=0.
- Undefined: no CFG_MATCH port and no comparator logic.

Test Plan:
- Reset check: RST=1 for 3 cycles -> every output is 0. Release with ARM=0 -> stays IDLE, outputs stay 0 over 100 cycles.
- Normal frame: ARM=1, SCLK=CLK/8, 16 bits of 16'hABC6 with SEL=1, then 88 bits of 88'h123456789ABCDEF1234567 with SEL=0 -> exactly one FRAME_VALID pulse, DYNCNF_OUT=16'hABC6, STATCNF_OUT=88'h123456789ABCDEF1234567, FRAME_DONE=1, ERR=0. With the check macro: CFG_MATCH=1. Flipping stat bit 0 gives CFG_MATCH=0.
- Short dynamic: 15 SEL=1 edges then a SEL=0 edge -> ERR=1, ERR_CODE=1, no FRAME_VALID, outputs unchanged.
- SEL violation: good dynamic word, then SEL=1 on static bit 40 -> ERR_CODE=2.
- Timeout and recovery: SCLK stops after 50 static bits -> ERR_CODE=3 64 cycles after the last edge. ARM=0 for 1 cycle -> ERR=0. Re-arm and send a full frame -> good latch.
- Reset mid-frame: RST pulse at dynamic bit 8 -> outputs 0, FSM IDLE. Next full frame (ARM held 1) latches correctly.
